// File: rtl/collision_pkg.sv
// Shared types and constants for the ball/target collision controller.
// The LFSR constants are only consumed when COLLISION_CATCH_RNG_EN is defined.
package collision_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TILT   = 2'd1,
        REST   = 2'd2,
        RESULT = 2'd3
    } col_state_e;

    localparam int unsigned CATCH_RATE_W = 9;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        logic [15:0] shifted;
        shifted = state >> 1;
        return state[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/overlap_counter.sv
// Saturating per-target overlap counter, cleared synchronously by i_clear.
// A clear wins over a same-cycle increment, so that pixel is not counted.
module overlap_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/collision_ctrl.sv
// Ball/target collision controller: per-frame overlap counting, hit select and shake animation.
// Define COLLISION_CATCH_RNG_EN to gate each shake with an LFSR draw against i_catch_rate.
module collision_ctrl
    import collision_pkg::*;
#(
    parameter int unsigned N_TARGET    = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned THRESH      = 10000,
    parameter int unsigned TILT_FRAMES = 12,
    parameter int unsigned REST_FRAMES = 52,
    parameter int unsigned N_SHAKE     = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_refresh,
    input  logic                          i_abort,
    input  logic [N_TARGET-1:0]           i_en_target,
    input  logic                          i_en_ball,
    input  logic                          i_z_neg,
    input  logic [CATCH_RATE_W-1:0]       i_catch_rate,
    output logic                          o_en_collision,
    output logic                          o_anime_ball,
    output logic [$clog2(N_TARGET)-1:0]   o_hit_idx,
    output logic [$clog2(N_SHAKE+1)-1:0]  o_shake_num,
    output logic                          o_collision_done,
    output logic                          o_caught
);

    localparam int unsigned IDX_W     = $clog2(N_TARGET);
    localparam int unsigned SHK_W     = $clog2(N_SHAKE + 1);
    localparam int unsigned FRAME_MAX = (TILT_FRAMES > REST_FRAMES) ? TILT_FRAMES : REST_FRAMES;
    localparam int unsigned FRM_W     = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;

    localparam logic [FRM_W-1:0] TILT_LAST  = FRM_W'(TILT_FRAMES - 1);
    localparam logic [FRM_W-1:0] REST_LAST  = FRM_W'(REST_FRAMES - 1);
    localparam logic [SHK_W-1:0] SHAKE_LAST = SHK_W'(N_SHAKE);
    localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(THRESH);

    logic [CNT_W-1:0] w_count [N_TARGET];
    logic             w_clear;
    logic             w_pix;
    logic             w_hit_any;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_pass;

    col_state_e       r_state, w_state_d;
    logic [FRM_W-1:0] r_frame, w_frame_d;
    logic [SHK_W-1:0] r_shake, w_shake_d;
    logic [SHK_W-1:0] w_shake_inc;
    logic [IDX_W-1:0] r_hit_idx, w_hit_idx_d;
    logic             r_caught, w_caught_d;
    logic             r_en, w_en_d;
    logic             r_anime, w_anime_d;
    logic             r_done, w_done_d;

    assign w_clear = i_refresh | i_abort;
    assign w_pix   = i_en_ball & i_z_neg;

    for (genvar k = 0; k < N_TARGET; k++) begin : g_cnt
        overlap_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clear (w_clear),
            .i_inc   (w_pix & i_en_target[k]),
            .o_count (w_count[k])
        );
    end

    // Walk from the top index down so the lowest qualifying target wins
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_idx = '0;
        for (int k = N_TARGET - 1; k >= 0; k--) begin
            if (w_count[k] > THRESH_C) begin
                w_hit_any = 1'b1;
                w_hit_idx = IDX_W'(k);
            end
        end
    end

`ifdef COLLISION_CATCH_RNG_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_pass = ({1'b0, r_lfsr[7:0]} < i_catch_rate);
`else
    logic w_unused_rate;

    assign w_unused_rate = ^i_catch_rate;
    assign w_pass        = 1'b1;
`endif

    assign w_shake_inc = r_shake + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_frame   <= '0;
            r_shake   <= '0;
            r_hit_idx <= '0;
            r_caught  <= 1'b0;
            r_en      <= 1'b0;
            r_anime   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_frame   <= w_frame_d;
            r_shake   <= w_shake_d;
            r_hit_idx <= w_hit_idx_d;
            r_caught  <= w_caught_d;
            r_en      <= w_en_d;
            r_anime   <= w_anime_d;
            r_done    <= w_done_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_frame_d   = r_frame;
        w_shake_d   = r_shake;
        w_hit_idx_d = r_hit_idx;
        w_caught_d  = r_caught;
        if (i_abort) begin
            w_state_d  = IDLE;
            w_frame_d  = '0;
            w_shake_d  = '0;
            w_caught_d = 1'b0;
        end else if (i_refresh) begin
            unique case (r_state)
                IDLE: begin
                    if (w_hit_any) begin
                        w_state_d   = TILT;
                        w_frame_d   = '0;
                        w_shake_d   = '0;
                        w_hit_idx_d = w_hit_idx;
                        w_caught_d  = 1'b0;
                    end
                end
                TILT: begin
                    if (r_frame == TILT_LAST) begin
                        w_state_d = REST;
                        w_frame_d = '0;
                    end else begin
                        w_frame_d = r_frame + 1'b1;
                    end
                end
                REST: begin
                    if (r_frame == REST_LAST) begin
                        w_frame_d = '0;
                        w_shake_d = w_shake_inc;
                        if (!w_pass) begin
                            w_state_d  = RESULT;
                            w_caught_d = 1'b0;
                        end else if (w_shake_inc == SHAKE_LAST) begin
                            w_state_d  = RESULT;
                            w_caught_d = 1'b1;
                        end else begin
                            w_state_d = TILT;
                        end
                    end else begin
                        w_frame_d = r_frame + 1'b1;
                    end
                end
                RESULT: begin
                    // No trigger evaluation on the frame that leaves RESULT
                    w_state_d  = IDLE;
                    w_caught_d = 1'b0;
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_en_d    = (w_state_d == TILT) || (w_state_d == REST);
        w_anime_d = (w_state_d == REST);
        w_done_d  = (w_state_d == RESULT);
    end

    assign o_en_collision   = r_en;
    assign o_anime_ball     = r_anime;
    assign o_hit_idx        = r_hit_idx;
    assign o_shake_num      = r_shake;
    assign o_collision_done = r_done;
    assign o_caught         = r_caught;

endmodule

// File: tb/tb_collision_ctrl.sv
// Self-checking bench for collision_ctrl against a frame-position reference model.
// The rate-gated scenario runs only when COLLISION_CATCH_RNG_EN is defined.
module tb_collision_ctrl;

    localparam int NT  = 4;
    localparam int THR = 10000;
    localparam int TF  = 12;
    localparam int RF  = 52;
    localparam int NS  = 3;
    localparam int PER = TF + RF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       refresh = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] en_t = '0;
    logic       ball = 1'b0;
    logic       z = 1'b0;
    logic [8:0] rate = '0;
    logic       o_en_collision, o_anime_ball, o_collision_done, o_caught;
    logic [1:0] o_hit_idx;
    logic [1:0] o_shake_num;

    // Model: counts per target, and position = refreshes since entering TILT
    int m_cnt [NT];
    bit m_active, m_result, m_caught;
    int m_pos, m_hit, m_shake;
    int n_ref;
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    collision_ctrl u_dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_refresh        (refresh),
        .i_abort          (abort),
        .i_en_target      (en_t),
        .i_en_ball        (ball),
        .i_z_neg          (z),
        .i_catch_rate     (rate),
        .o_en_collision   (o_en_collision),
        .o_anime_ball     (o_anime_ball),
        .o_hit_idx        (o_hit_idx),
        .o_shake_num      (o_shake_num),
        .o_collision_done (o_collision_done),
        .o_caught         (o_caught)
    );

    function automatic bit model_pass();
`ifdef COLLISION_CATCH_RNG_EN
        return (rate == 9'd256);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [3:0] exp_flags();
        return {m_active, m_active && ((m_pos % PER) >= TF), m_result, m_result && m_caught};
    endfunction

    task automatic model_reset();
        m_active = 0; m_result = 0; m_caught = 0;
        m_pos = 0; m_hit = 0; m_shake = 0;
        for (int k = 0; k < NT; k++) m_cnt[k] = 0;
    endtask

    task automatic drive(input logic [3:0] t, input logic b, input logic zz,
                         input logic r, input logic a);
        int f;
        en_t = t; ball = b; z = zz; refresh = r; abort = a;
        if (a) begin
            m_active = 0; m_result = 0; m_caught = 0; m_shake = 0; m_pos = 0;
            for (int k = 0; k < NT; k++) m_cnt[k] = 0;
        end else if (r) begin
            if (m_result) begin
                m_result = 0; m_caught = 0;
            end else if (m_active) begin
                m_pos++;
                if (m_pos % PER == 0) begin
                    m_shake = m_pos / PER;
                    if (!model_pass()) begin
                        m_active = 0; m_result = 1; m_caught = 0;
                    end else if (m_shake == NS) begin
                        m_active = 0; m_result = 1; m_caught = 1;
                    end
                end
            end else begin
                f = -1;
                for (int k = NT - 1; k >= 0; k--) if (m_cnt[k] > THR) f = k;
                if (f >= 0) begin
                    m_active = 1; m_pos = 0; m_shake = 0; m_hit = f; m_caught = 0;
                end
            end
            for (int k = 0; k < NT; k++) m_cnt[k] = 0;
        end else begin
            for (int k = 0; k < NT; k++)
                if (t[k] && b && zz && m_cnt[k] < 65535) m_cnt[k]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_en_collision, o_anime_ball, o_collision_done, o_caught} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000",
                     {o_en_collision, o_anime_ball, o_collision_done, o_caught});
        else passes++;
        checks++;
        if (o_hit_idx !== 2'd0) $display("FAIL reset_hit_idx: got %0d want 0", o_hit_idx);
        else passes++;
        checks++;
        if (o_shake_num !== 2'd0) $display("FAIL reset_shake: got %0d want 0", o_shake_num);
        else passes++;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_trigger();
`ifdef COLLISION_CATCH_RNG_EN
        rate = 9'd256;
`else
        rate = 9'($urandom_range(0, 256));
`endif
        for (int i = 0; i < 20000 && m_cnt[2] < THR + 1; i++)
            drive({1'($urandom), 1'b1, 2'b00}, ($urandom % 16) != 0, 1'b1, 1'b0, 1'b0);
        drive(4'b0100, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (o_en_collision !== 1'b1) $display("FAIL trig_en: got %b want 1", o_en_collision);
        else passes++;
        checks++;
        if (o_hit_idx !== 2'd2) $display("FAIL trig_hit_idx: got %0d want 2", o_hit_idx);
        else passes++;
        checks++;
        if ({o_anime_ball, o_collision_done} !== 2'b00)
            $display("FAIL trig_anime_done: got %b want 00", {o_anime_ball, o_collision_done});
        else passes++;
        for (int i = 1; i <= TF; i++) begin
            drive(4'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
            drive(4'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
            if (i == TF - 1) begin
                checks++;
                if (o_anime_ball !== 1'b0) $display("FAIL tilt_11: got %b want 0", o_anime_ball);
                else passes++;
            end
        end
        checks++;
        if ({o_en_collision, o_anime_ball} !== 2'b11)
            $display("FAIL rest_entry: got %b want 11", {o_en_collision, o_anime_ball});
        else passes++;
        n_ref = TF;
    endtask

    task automatic test_full_run();
        for (int it = 0; it < 400 && !m_result; it++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g <= gap; g++) begin
                drive(4'($urandom), 1'($urandom), 1'($urandom), g == gap, 1'b0);
                if (g == gap) n_ref++;
                checks++;
                if ({o_en_collision, o_anime_ball, o_collision_done, o_caught} !== exp_flags())
                    $display("FAIL run_flags: ref %0d got %b want %b", n_ref,
                             {o_en_collision, o_anime_ball, o_collision_done, o_caught},
                             exp_flags());
                else passes++;
                checks++;
                if (o_shake_num !== 2'(m_shake))
                    $display("FAIL run_shake: ref %0d got %0d want %0d", n_ref, o_shake_num,
                             m_shake);
                else passes++;
            end
        end
        checks++;
        if (n_ref != NS * PER) $display("FAIL run_length: got %0d want %0d", n_ref, NS * PER);
        else passes++;
        checks++;
        if ({o_collision_done, o_caught, o_shake_num} !== 4'b1111)
            $display("FAIL run_result: got %b want 1111",
                     {o_collision_done, o_caught, o_shake_num});
        else passes++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < THR + 1; i++) drive(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({o_collision_done, o_caught} !== 2'b11)
            $display("FAIL b2b_hold: got %b want 11", {o_collision_done, o_caught});
        else passes++;
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({o_en_collision, o_collision_done, o_caught} !== 3'b000)
            $display("FAIL b2b_exit: got %b want 000",
                     {o_en_collision, o_collision_done, o_caught});
        else passes++;
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (o_en_collision !== 1'b0) $display("FAIL b2b_next: got %b want 0", o_en_collision);
        else passes++;
    endtask

    task automatic test_threshold();
        for (int i = 0; i < THR; i++) drive(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(4'b0001, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (o_en_collision !== 1'b0)
            $display("FAIL thresh_equal: got %b want 0", o_en_collision);
        else passes++;
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (o_en_collision !== 1'(m_active))
            $display("FAIL thresh_after: got %b want %b", o_en_collision, m_active);
        else passes++;
    endtask

    task automatic test_priority();
        for (int i = 0; i < 12000; i++) drive(4'b1010, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(4'b1010, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({o_en_collision, o_anime_ball} !== 2'b10)
            $display("FAIL prio_state: got %b want 10", {o_en_collision, o_anime_ball});
        else passes++;
        checks++;
        if (o_hit_idx !== 2'd1) $display("FAIL prio_hit_idx: got %0d want 1", o_hit_idx);
        else passes++;
    endtask

    task automatic test_abort();
        for (int i = 0; i < PER + PER - 1; i++) begin
            drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if ({o_anime_ball, o_shake_num} !== 3'b101)
            $display("FAIL abort_pre: got %b want 101", {o_anime_ball, o_shake_num});
        else passes++;
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({o_en_collision, o_anime_ball, o_collision_done, o_caught, o_shake_num} !== 6'd0)
            $display("FAIL abort_idle: got %b want 000000",
                     {o_en_collision, o_anime_ball, o_collision_done, o_caught, o_shake_num});
        else passes++;
        checks++;
        if (o_hit_idx !== 2'd1) $display("FAIL abort_hit_keep: got %0d want 1", o_hit_idx);
        else passes++;
        for (int i = 0; i < 200; i++) begin
            drive(4'b0000, 1'b0, 1'b0, i % 2 == 1, 1'b0);
            checks++;
            if ({o_en_collision, o_collision_done} !== 2'b00)
                $display("FAIL abort_quiet: cycle %0d got %b want 00", i,
                         {o_en_collision, o_collision_done});
            else passes++;
        end
    endtask

    task automatic test_abort_clear();
        for (int i = 0; i < THR + 1; i++) drive(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({o_en_collision, o_hit_idx} !== 3'b001)
            $display("FAIL abort_clears_cnt: got %b want 001", {o_en_collision, o_hit_idx});
        else passes++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < THR + 1; i++) drive(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({o_en_collision, o_hit_idx} !== 3'b111)
            $display("FAIL ares_trigger: got %b want 111", {o_en_collision, o_hit_idx});
        else passes++;
        for (int i = 0; i < 5; i++) drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_en_collision, o_anime_ball, o_collision_done, o_caught, o_hit_idx,
             o_shake_num} !== 8'd0)
            $display("FAIL ares_immediate: got %b want 00000000",
                     {o_en_collision, o_anime_ball, o_collision_done, o_caught, o_hit_idx,
                      o_shake_num});
        else passes++;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

`ifdef COLLISION_CATCH_RNG_EN
    task automatic test_rng_fail();
        int n;
        rate = 9'd0;
        for (int i = 0; i < THR + 1; i++) drive(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        n = 0;
        for (int it = 0; it < 300 && !m_result; it++) begin
            drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
            n++;
            checks++;
            if ({o_en_collision, o_anime_ball, o_collision_done, o_caught} !== exp_flags())
                $display("FAIL rng_flags: ref %0d got %b want %b", n,
                         {o_en_collision, o_anime_ball, o_collision_done, o_caught},
                         exp_flags());
            else passes++;
        end
        checks++;
        if (n != PER) $display("FAIL rng_length: got %0d want %0d", n, PER);
        else passes++;
        checks++;
        if ({o_collision_done, o_caught, o_shake_num} !== 4'b1001)
            $display("FAIL rng_result: got %b want 1001",
                     {o_collision_done, o_caught, o_shake_num});
        else passes++;
        drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_trigger();
        test_full_run();
        test_back_to_back();
        test_threshold();
        test_priority();
        test_abort();
        test_abort_clear();
        test_async_reset();
`ifdef COLLISION_CATCH_RNG_EN
        test_rng_fail();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/collision_ctrl.md
# collision_ctrl

Parametrised ball–target collision controller for the catch sequence. It counts overlapping ball/target pixels per target over each frame. At a frame boundary it picks the first target whose count exceeds a threshold. It then runs a configurable tilt/rest shake animation and reports a catch outcome. It sits between the pixel-level sprite compositor (which supplies per-pixel enables and the depth test) and the game FSM (which consumes the done/caught result).

## Interface
- `N_TARGET`, 4 — number of target sprites tracked.
- `CNT_W`, 16 — width of each per-target overlap counter.
- `THRESH`, 10000 — a hit requires overlap count strictly greater than this.
- `TILT_FRAMES`, 12 — frames per tilt phase.
- `REST_FRAMES`, 52 — frames per rest phase.
- `N_SHAKE`, 3 — shakes (tilt+rest pairs) before a guaranteed catch.
- `i_clk`  in  1  — system clock.
- `i_rst_n`  in  1  — asynchronous, active-low reset.
- `i_refresh`  in  1  — one-cycle frame-boundary pulse.
- `i_abort`  in  1  — synchronous cancel of any sequence in progress.
- `i_en_target`  in  N_TARGET  — target k covers the current pixel.
- `i_en_ball`  in  1  — ball covers the current pixel.
- `i_z_neg`  in  1  — depth test passes (ball in front) for the current pixel.
- `i_catch_rate`  in  9  — per-shake pass threshold, 0..256.
- `o_en_collision`  out  1  — sequence active (TILT or REST).
- `o_anime_ball`  out  1  — REST phase (ball drawn upright).
- `o_hit_idx`  out  $clog2(N_TARGET)  — index of the captured target, held until the next trigger.
- `o_shake_num`  out  $clog2(N_SHAKE+1)  — shakes completed in the current sequence.
- `o_collision_done`  out  1  — high for exactly one frame (RESULT state).
- `o_caught`  out  1  — outcome; valid while `o_collision_done` is high, 0 otherwise.

## Operation
- **Counters.** Per target k: increments on cycles where `i_en_target[k] & i_en_ball & i_z_neg`. Saturates at 2^CNT_W−1. Clears to 0 on `i_refresh`; refresh wins over a same-cycle increment, so that pixel is dropped. Counting continues in all states.
- **States:** IDLE, TILT, REST, RESULT. All transitions occur only on cycles with `i_refresh`=1, except abort.
- **IDLE.** On refresh, if any pre-clear count > THRESH, go to TILT. Latch `o_hit_idx` as the lowest such index. Clear the frame counter and `o_shake_num`.
- **TILT.** The frame counter increments on each refresh. On the refresh where it equals TILT_FRAMES−1, go to REST and clear the frame counter.
- **REST.** On the refresh where the frame counter equals REST_FRAMES−1:
  - increment the shake count;
  - if the shake passed (see Configuration) and the shake count < N_SHAKE, go to TILT;
  - if the shake passed and N_SHAKE shakes are done, go to RESULT with caught=1;
  - if the shake failed, go to RESULT with caught=0.
- **RESULT.** Lasts one frame. On the next refresh, go to IDLE and drop done/caught. Triggers are not evaluated in this refresh; the earliest re-trigger is the refresh after that.
- **Abort.** `i_abort` takes priority over everything else, including a same-cycle refresh. Next cycle: IDLE, with frame counter, shake count, done, caught and all overlap counters at 0. No done pulse is produced. `o_hit_idx` is retained.
- **Reset values.** All outputs and counters are 0 and the state is IDLE. The LFSR is at its seed.

## Timing
- All outputs are registered. A state change on a refresh cycle is visible on outputs at the next clock edge (1-cycle latency).
- Trigger-to-TILT latency is 1 cycle after the evaluating refresh.
- Full successful sequence: N_SHAKE×(TILT_FRAMES+REST_FRAMES) refreshes from entering TILT to entering RESULT (192 refreshes with defaults).
- `o_collision_done` is high from 1 cycle after the refresh entering RESULT until 1 cycle after the following refresh.
- Reset asserted mid-sequence forces the reset values immediately (asynchronous). No done pulse is produced.

## Configuration
- `COLLISION_CATCH_RNG_EN` defined:
  - A 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advances every clock.
  - At the end of each REST phase, the shake passes iff {1'b0, lfsr[7:0]} < `i_catch_rate`.
  - Consequences: rate 0 always fails; rate 256 always passes.
- Not defined:
  - No LFSR is built and `i_catch_rate` is ignored.
  - Every shake passes; the result is always caught=1 after N_SHAKE shakes.

## Structure
- Package `collision_pkg` holds:
  - the state enum `col_state_e` (IDLE, TILT, REST, RESULT);
  - the LFSR seed and tap constants;
  - the `CATCH_RATE_W`=9 constant.
- Sub-module `overlap_counter`: one saturating, refresh-cleared counter, instantiated N_TARGET times via generate.
- The top module holds the hit-select priority encoder, the FSM, the frame/shake counters and the optional LFSR.

## Test plan
- 10001 qualifying pixels on target 2, then refresh → next cycle `o_en_collision`=1, `o_hit_idx`=2, `o_anime_ball`=0; after 12 more refreshes `o_anime_ball`=1.
- Exactly 10000 pixels on target 0, then refresh → remains IDLE, `o_en_collision`=0.
- Targets 1 and 3 both at 12000, pixel coinciding with refresh dropped → `o_hit_idx`=1; counters read 0 after refresh.
- Macro off, full run → after 192 refreshes `o_collision_done`=1, `o_caught`=1, `o_shake_num`=3 for exactly one frame, then IDLE.
- `i_abort` during REST of shake 2, simultaneous with a refresh → IDLE next cycle, done never asserts, `o_shake_num`=0.
- Macro on: `i_catch_rate`=0 → RESULT after 64 refreshes with caught=0, `o_shake_num`=1; `i_catch_rate`=256 → caught=1 after 192 refreshes.
